// File: rtl/median_filter_pkg.sv
// Shared mode encodings and rank-selection helper for the streaming order-statistic filter.
package median_filter_pkg;

  localparam logic [1:0] MODE_MEDIAN = 2'b00;
  localparam logic [1:0] MODE_MIN    = 2'b01;
  localparam logic [1:0] MODE_MAX    = 2'b10;
  localparam logic [1:0] MODE_BYPASS = 2'b11;

  // Rank K of the element to output; bypass never consults it, so it reuses the median rank.
  function automatic int unsigned rank_for_mode(input logic [1:0] mode,
                                                input int unsigned window_size);
    int unsigned k;
    k = (window_size - 1) / 2;
    case (mode)
      MODE_MIN: k = 0;
      MODE_MAX: k = window_size - 1;
      default:  k = (window_size - 1) / 2;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/median_filter_stream_rank_select.sv
// Combinational order-statistic selector: picks the window element whose unique rank equals K.
module rank_select #(
  parameter  int DATA_WIDTH  = 8,
  parameter  int WINDOW_SIZE = 3,
  localparam int CNT_W       = $clog2(WINDOW_SIZE + 1)
) (
  input  logic [WINDOW_SIZE*DATA_WIDTH-1:0] i_window,
  input  logic [CNT_W-1:0]                  i_rank,
  output logic [DATA_WIDTH-1:0]             o_data
);

  logic [DATA_WIDTH-1:0]  w_x      [WINDOW_SIZE];
  logic [WINDOW_SIZE-1:0] w_before [WINDOW_SIZE];
  logic [CNT_W-1:0]       w_rank   [WINDOW_SIZE];

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned,
  // which is what keeps synthesis from inferring a latch.
  always_comb begin
    o_data = '0;
    for (int i = 0; i < WINDOW_SIZE; i++) begin
      w_x[i]      = i_window[i*DATA_WIDTH +: DATA_WIDTH];
      w_before[i] = '0;
      w_rank[i]   = '0;
    end

    // Equal values are ordered by window index, so every element gets a distinct rank.
    for (int i = 0; i < WINDOW_SIZE; i++) begin
      for (int j = 0; j < WINDOW_SIZE; j++) begin
        w_before[i][j] = (w_x[j] < w_x[i]) || ((w_x[j] == w_x[i]) && (j < i));
      end
    end

    for (int i = 0; i < WINDOW_SIZE; i++) begin
      for (int j = 0; j < WINDOW_SIZE; j++) begin
        w_rank[i] = w_rank[i] + CNT_W'(w_before[i][j]);
      end
    end

    for (int i = 0; i < WINDOW_SIZE; i++) begin
      if (w_rank[i] == i_rank) begin
        o_data = w_x[i];
      end
    end
  end

endmodule

// File: rtl/median_filter_stream.sv
// Streaming sliding-window median/min/max/bypass filter with valid/ready on both sides.
module median_filter_stream
  import median_filter_pkg::*;
#(
  parameter  int DATA_WIDTH  = 8,
  parameter  int WINDOW_SIZE = 3,
  localparam int CNT_W       = $clog2(WINDOW_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      fill
);

  if ((WINDOW_SIZE < 3) || (WINDOW_SIZE > 9) || ((WINDOW_SIZE % 2) == 0)) begin : g_bad_window
    $error("median_filter_stream: WINDOW_SIZE must be odd and in 3..9");
  end

  // The newest window slot is always in_data itself, so only the older samples are stored.
  localparam int HIST = WINDOW_SIZE - 1;

  logic [DATA_WIDTH-1:0]             r_win [HIST];
  logic [CNT_W-1:0]                  r_fill;
  logic                              r_out_valid;
  logic [DATA_WIDTH-1:0]             r_out_data;

  logic                              w_in_ready;
  logic                              w_accept;
  logic [CNT_W-1:0]                  w_fill_next;
  logic                              w_load;
  logic [CNT_W-1:0]                  w_rank;
  logic [WINDOW_SIZE*DATA_WIDTH-1:0] w_post_window;
  logic [DATA_WIDTH-1:0]             w_selected;

  assign w_in_ready  = !clear && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && w_in_ready;
  assign w_fill_next = (r_fill == CNT_W'(WINDOW_SIZE)) ? r_fill : r_fill + 1'b1;
  assign w_load      = w_accept && ((mode == MODE_BYPASS) || (w_fill_next == CNT_W'(WINDOW_SIZE)));
  assign w_rank      = CNT_W'(rank_for_mode(mode, WINDOW_SIZE));

  always_comb begin
    w_post_window                 = '0;
    w_post_window[DATA_WIDTH-1:0] = in_data;
    for (int i = 1; i < WINDOW_SIZE; i++) begin
      w_post_window[i*DATA_WIDTH +: DATA_WIDTH] = r_win[i-1];
    end
  end

  rank_select #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WINDOW_SIZE (WINDOW_SIZE)
  ) u_rank_select (
    .i_window (w_post_window),
    .i_rank   (w_rank),
    .o_data   (w_selected)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
  // the window array is explicitly reset because a flushed window must read as zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST; i++) r_win[i] <= '0;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (clear) begin
      for (int i = 0; i < HIST; i++) r_win[i] <= '0;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_win[0] <= in_data;
        for (int i = 1; i < HIST; i++) r_win[i] <= r_win[i-1];
        r_fill <= w_fill_next;
      end
      // A load and a drain in the same cycle is legal: the new result simply replaces the old.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= (mode == MODE_BYPASS) ? in_data : w_selected;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign fill      = r_fill;

endmodule
